// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding an 8-bit LSB-first UART transmitter.
//               Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       send_request,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);
    localparam int CLKS_IN_BAUD = CLK_HZ / BAUD;
    localparam int BAUD_W       = (CLKS_IN_BAUD > 1) ? $clog2(CLKS_IN_BAUD) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_IN_BAUD - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                tx_q, tx_d;
    logic                overflow_q, overflow_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic wr_en;
    logic pop;
    logic baud_end;

    assign full     = (count_q == CNT_FULL);
    assign busy     = (state_q != ST_IDLE) || (count_q != '0);
    assign overflow = overflow_q;
    assign tx       = tx_q;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        pop        = 1'b0;
        // Full comes from the registered count, so a pop in the same cycle never frees a slot early.
        wr_en      = send_request && !full;
        overflow_d = send_request && full;
        baud_end   = (baud_cnt_q == BAUD_LAST);

        if (state_q != ST_IDLE) begin
            baud_cnt_d = baud_end ? '0 : baud_cnt_q + BAUD_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) pop = 1'b1;
            end
            ST_START: begin
                if (baud_end) begin
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A pop loads the head byte and starts the start bit on the same edge.
        if (pop) begin
            shreg_d    = mem_q[rd_ptr_q];
            tx_d       = 1'b0;
            state_d    = ST_START;
            baud_cnt_d = '0;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^mem_q[rd_ptr_q];
`endif
        end

        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= tx_byte;
    end

endmodule
`default_nettype wire
